// File: rtl/global_sram_arbiter.sv
// ---------------------------------------------------------------------------
// global_sram_arbiter
//
// Shares the single-port global SRAM between three clients:
//   WB   - vector-out writeback path (writes only)
//   RD   - streaming read controller (reads only)
//   HOST - host/debug port (reads or writes)
// One access per cycle.
//
// Arbitration:
//   - Base priority is WB > RD > HOST.
//   - Each client has its own starvation counter. A client that reaches
//     STARVE_MAX denied cycles in a row is promoted above non-starved clients.
//
// Command and read return:
//   - The SRAM command is registered one cycle after the grant.
//   - A read tag follows each command through a small pipeline so that the
//     returning word is delivered to the client that issued the read.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   rd_req/rd_addr/rd_gnt          RD request channel
//   rd_rdata/rd_rvld               RD read return
//   wb_req/wb_addr/wb_wdata/wb_gnt WB write channel
//   host_req/host_we/host_addr/
//   host_wdata/host_gnt            HOST request channel
//   host_rdata/host_rvld           HOST read return
//   sram_cen/wen/addr/wdata        registered SRAM command
//   sram_rdata                     SRAM read data, RD_LAT cycles after cen
//   busy                           any request pending or any read in flight
// ---------------------------------------------------------------------------
module global_sram_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 128,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_rdata,
    output logic              rd_rvld,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              wb_gnt,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvld,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    // Requester index doubles as base priority (lower index wins).
    localparam int WB   = 0;
    localparam int RD   = 1;
    localparam int HOST = 2;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_RD   = 2'd1;
    localparam logic [1:0] TAG_HOST = 2'd2;

    logic [2:0] req_vec;
    logic [2:0] starved;
    logic [2:0] gnt_vec;

    assign req_vec = {host_req, rd_req, wb_req};

    // -----------------------------------------------------------------------
    // Per-requester starvation counters
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_starve
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            always_comb begin
                cnt_next = '0;
                if (req_vec[gi] && !gnt_vec[gi]) begin
                    cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign starved[gi] = req_vec[gi] && (cnt_reg == CNT_MAX);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Grant: starved requesters first, base priority breaks ties
    // -----------------------------------------------------------------------
    always_comb begin
        gnt_vec = '0;
        if (|starved) begin
            if (starved[WB])      gnt_vec[WB]   = 1'b1;
            else if (starved[RD]) gnt_vec[RD]   = 1'b1;
            else                  gnt_vec[HOST] = 1'b1;
        end else begin
            if (req_vec[WB])        gnt_vec[WB]   = 1'b1;
            else if (req_vec[RD])   gnt_vec[RD]   = 1'b1;
            else if (req_vec[HOST]) gnt_vec[HOST] = 1'b1;
        end
    end

    assign wb_gnt   = gnt_vec[WB];
    assign rd_gnt   = gnt_vec[RD];
    assign host_gnt = gnt_vec[HOST];

    // -----------------------------------------------------------------------
    // Winner's command and return tag
    // -----------------------------------------------------------------------
    logic              sram_cen_reg;
    logic              sram_wen_reg;
    logic [ADDR_W-1:0] sram_addr_reg;
    logic [DATA_W-1:0] sram_wdata_reg;

    logic              cmd_we_next;
    logic [ADDR_W-1:0] cmd_addr_next;
    logic [DATA_W-1:0] cmd_wdata_next;
    logic [1:0]        tag_next;

    always_comb begin
        cmd_we_next    = 1'b0;
        cmd_addr_next  = sram_addr_reg;
        cmd_wdata_next = sram_wdata_reg;
        tag_next       = TAG_NONE;
        if (gnt_vec[WB]) begin
            cmd_we_next    = 1'b1;
            cmd_addr_next  = wb_addr;
            cmd_wdata_next = wb_wdata;
        end else if (gnt_vec[RD]) begin
            // RD has no write data, so the write-data bus keeps its value.
            cmd_addr_next  = rd_addr;
            tag_next       = TAG_RD;
        end else if (gnt_vec[HOST]) begin
            cmd_we_next    = host_we;
            cmd_addr_next  = host_addr;
            cmd_wdata_next = host_wdata;
            tag_next       = host_we ? TAG_NONE : TAG_HOST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_cen_reg   <= 1'b0;
            sram_wen_reg   <= 1'b0;
            sram_addr_reg  <= '0;
            sram_wdata_reg <= '0;
        end else begin
            sram_cen_reg   <= |gnt_vec;
            sram_wen_reg   <= cmd_we_next;
            sram_addr_reg  <= cmd_addr_next;
            sram_wdata_reg <= cmd_wdata_next;
        end
    end

    assign sram_cen   = sram_cen_reg;
    assign sram_wen   = sram_wen_reg;
    assign sram_addr  = sram_addr_reg;
    assign sram_wdata = sram_wdata_reg;

    // -----------------------------------------------------------------------
    // Tag pipeline: stage 0 lines up with sram_cen, stage RD_LAT lines up
    // with the returning sram_rdata.
    // -----------------------------------------------------------------------
    logic [RD_LAT:0][1:0] tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_reg <= '0;
        end else begin
            tag_reg <= {tag_reg[RD_LAT-1:0], tag_next};
        end
    end

    assign rd_rvld   = (tag_reg[RD_LAT] == TAG_RD);
    assign host_rvld = (tag_reg[RD_LAT] == TAG_HOST);

    // The macro's word is only present during the rvld cycle, so it is
    // passed through on that cycle and captured for the cycles after.
    logic [DATA_W-1:0] rd_hold_reg;
    logic [DATA_W-1:0] host_hold_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hold_reg   <= '0;
            host_hold_reg <= '0;
        end else begin
            if (rd_rvld)   rd_hold_reg   <= sram_rdata;
            if (host_rvld) host_hold_reg <= sram_rdata;
        end
    end

    assign rd_rdata   = rd_rvld   ? sram_rdata : rd_hold_reg;
    assign host_rdata = host_rvld ? sram_rdata : host_hold_reg;

    assign busy = (|req_vec) || (|tag_reg);

endmodule
